irq_request_source: RTL

- Request-side counterpart of the 27-channel priority interrupt controller benchmark (3 groups A/B/C × 9 channels, shared 9-bit enable bus).
- Captures per-channel event edges into pending bits and drives the controller's A/B/C request buses.
- Accepts the acknowledge (group + encoded channel) returned from the controller and clears the serviced bit.
- Tracks one in-service interrupt until end-of-interrupt (EOI).

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_edge_bank.sv | 28 ++
 rtl/irq_request_source.sv | 127 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants, group codes, FSM state type and channel indexing for the interrupt request source.
package irq_pkg;
   localparam int NCH     = 9;
   localparam int NGRP    = 3;
   localparam int TIMEOUT = 255;

   localparam logic [1:0] GRP_A = 2'd0;
   localparam logic [1:0] GRP_B = 2'd1;
   localparam logic [1:0] GRP_C = 2'd2;

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_e;

   // Flat event/pending bit number for a group/channel pair; only meaningful for legal codes.
   function automatic logic [4:0] chan_index(input logic [1:0] grp, input logic [3:0] chan);
      logic [5:0] idx;
      idx = {4'b0, grp} * 6'(NCH) + {2'b0, chan};
      return idx[4:0];
   endfunction
endpackage

// File: rtl/irq_edge_bank.sv
// Rising-edge capture into pending bits for one group; set is visible the cycle after the edge.
// A new edge coinciding with a clear wins, so the bit stays pending.
module irq_edge_bank
   import irq_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] evt_i,
   input  logic [NCH-1:0] clr_i,
   output logic [NCH-1:0] pend_o
);
   logic [NCH-1:0] evt_prev_q;
   logic [NCH-1:0] pend_q;
   logic [NCH-1:0] pend_d;

   assign pend_d = (pend_q & ~clr_i) | (evt_i & ~evt_prev_q);
   assign pend_o = pend_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_prev_q <= '0;
         pend_q     <= '0;
      end else begin
         evt_prev_q <= evt_i;
         pend_q     <= pend_d;
      end
   end
endmodule

// File: rtl/irq_request_source.sv
// Request side of a 27-channel interrupt controller: pending capture, request buses, ack/EOI FSM.
// irq_o rises two cycles after an event edge; acks are only accepted (ack_ready_o) in REQ.
module irq_request_source
   import irq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [26:0] evt_i,
   input  logic [8:0]  en_i,
   output logic [8:0]  req_a_o,
   output logic [8:0]  req_b_o,
   output logic [8:0]  req_c_o,
   output logic        irq_o,
   input  logic        ack_valid_i,
   input  logic [1:0]  ack_grp_i,
   input  logic [3:0]  ack_chan_i,
   output logic        ack_ready_o,
   input  logic        eoi_i,
   output logic        in_service_o,
   output logic [1:0]  svc_grp_o,
   output logic [3:0]  svc_chan_o,
   output logic        err_o,
   output logic        timeout_o,
   input  logic        clr_err_i
);
   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        to_q, to_d;
   logic [1:0]  svc_grp_q, svc_grp_d;
   logic [3:0]  svc_chan_q, svc_chan_d;

   logic [8:0]  pend_a, pend_b, pend_c;
   logic [26:0] pend_all;
   logic [31:0] pend_ext;
   logic [15:0] en_ext;
   logic [26:0] clr_all;
   logic [4:0]  ack_idx;
   logic        ack_ok;
   logic        any_en;
   logic        in_req;
   logic        err_set;
   logic        to_set;

   irq_edge_bank u_bank_a (.clk(clk), .rst(rst), .evt_i(evt_i[8:0]),   .clr_i(clr_all[8:0]),   .pend_o(pend_a));
   irq_edge_bank u_bank_b (.clk(clk), .rst(rst), .evt_i(evt_i[17:9]),  .clr_i(clr_all[17:9]),  .pend_o(pend_b));
   irq_edge_bank u_bank_c (.clk(clk), .rst(rst), .evt_i(evt_i[26:18]), .clr_i(clr_all[26:18]), .pend_o(pend_c));

   assign pend_all = {pend_c, pend_b, pend_a};
   // Zero padding keeps out-of-range ack codes from indexing past the real bits.
   assign pend_ext = {5'b0, pend_all};
   assign en_ext   = {7'b0, en_i};
   assign in_req   = (state_q == REQ);
   assign any_en   = |(pend_all & {3{en_i}});
   assign ack_idx  = chan_index(ack_grp_i, ack_chan_i);
   assign ack_ok   = ack_valid_i && in_req && (ack_grp_i < 2'(NGRP)) && (ack_chan_i < 4'(NCH))
                     && pend_ext[ack_idx] && en_ext[ack_chan_i];

   always_comb begin
      clr_all = '0;
      if (ack_ok) clr_all[ack_idx] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      svc_grp_d  = svc_grp_q;
      svc_chan_d = svc_chan_q;
      err_set    = 1'b0;
      to_set     = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_en) state_d = REQ;
            if (eoi_i) err_set = 1'b1;
         end
         REQ: begin
            cnt_d = (cnt_q == 8'(TIMEOUT)) ? cnt_q : cnt_q + 8'd1;
            if (eoi_i) err_set = 1'b1;
            if (ack_ok) begin
               state_d    = SVC;
               cnt_d      = '0;
               svc_grp_d  = ack_grp_i;
               svc_chan_d = ack_chan_i;
            end else begin
               if (ack_valid_i) err_set = 1'b1;
               if (cnt_q == 8'(TIMEOUT - 1)) to_set = 1'b1;
               if (!any_en) state_d = IDLE;
            end
         end
         SVC: begin
            if (eoi_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      err_d = err_set ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
      to_d  = to_set  ? 1'b1 : (clr_err_i ? 1'b0 : to_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         to_q       <= 1'b0;
         svc_grp_q  <= '0;
         svc_chan_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         to_q       <= to_d;
         svc_grp_q  <= svc_grp_d;
         svc_chan_q <= svc_chan_d;
      end
   end

   assign req_a_o      = pend_a & en_i & {9{in_req}};
   assign req_b_o      = pend_b & en_i & {9{in_req}};
   assign req_c_o      = pend_c & en_i & {9{in_req}};
   assign irq_o        = in_req;
   assign ack_ready_o  = in_req;
   assign in_service_o = (state_q == SVC);
   assign svc_grp_o    = svc_grp_q;
   assign svc_chan_o   = svc_chan_q;
   assign err_o        = err_q;
   assign timeout_o    = to_q;
endmodule
